mem_requester: RTL and testbench
================================

# mem_requester

Initiator-side bridge between a core's load/store unit and the 68-bit put/get word-memory interface (request = {byte_en[3:0], addr[31:0], data[31:0]}, byte_en 4'b0000 = read). Converts sized byte/half/word accesses into aligned word requests, tracks up to DEPTH outstanding accesses in a metadata FIFO, and post-processes memory responses by shift and sign/zero extension. Responses return strictly in request order. Misaligned or illegal accesses never reach memory and are answered locally, still in order.

## Interface
- DEPTH, 2: maximum outstanding accesses, power of two, ≥2.
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_enable  in  1  core request strobe; asserted only while req_ready=1.
- req_ready  out  1  request can be accepted this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_unsigned  in  1  loads: zero-extend if 1, sign-extend if 0.
- req_addr  in  32  byte address.
- req_data  in  32  store data, right-aligned.
- rsp_enable  in  1  core takes response; asserted only while rsp_ready=1.
- rsp_ready  out  1  response available.
- rsp_data  out  32  extended load data; 0 for stores and errors.
- rsp_misaligned  out  1  response is a locally generated error.
- mem_put_enable  out  1  issue mem_put_request.
- mem_put_ready  in  1  memory accepts a request.
- mem_put_request  out  68  {byte_en, word-aligned addr, shifted data}.
- mem_get_enable  out  1  consume mem_get_response.
- mem_get_ready  in  1  memory response valid.
- mem_get_response  in  68  {byte_en echo, addr echo, data}.
- protocol_error  out  1  sticky: memory response mismatched FIFO head.

## Operation
- Offset o = req_addr[1:0]. Misaligned when size=3, size=1 with o[0]=1, or size=2 with o≠0.
- byte_en for stores: byte 4'b0001<<o, half 4'b0011<<o, word 4'b1111. Loads always 4'b0000.
- Store data: byte {4{data[7:0]}}, half {2{data[15:0]}}, word data. Loads send 0. Address sent = {req_addr[31:2],2'b00}.
- Metadata FIFO entry: {local, store, size, unsigned, o, word addr}. Occupancy counter 0..DEPTH; head and tail pointers wrap modulo DEPTH.
- Accept (req_enable && req_ready) always enqueues an entry. Only non-misaligned accepts also assert mem_put_enable.
- req_ready = !RST && count<DEPTH && (misaligned || mem_put_ready). mem_put_enable = req_enable && !misaligned && count<DEPTH.
- Head local=1: rsp_ready=1. Response is rsp_misaligned=1, rsp_data=0, and mem_get_enable stays 0.
- Head local=0: rsp_ready = mem_get_ready. mem_get_enable = rsp_enable. Load data w = mem data>>(8·o). Byte takes w[7:0], half takes w[15:0]; each is extended per unsigned. Word passes through. Stores return 0.
- On each consumed memory response, protocol_error is set if the echoed addr ≠ head addr, or if echoed byte_en≠0 differs from head.store.
- Full FIFO: req_ready=0 even when a dequeue occurs in the same cycle. No full bypass.
- Enqueue and dequeue in the same cycle (not full): count unchanged, both pointers advance.

## Timing
- Request path is combinational: accept and memory issue happen in the same cycle. Entry is visible at head next cycle.
- Response path is combinational from mem_get_response/mem_get_ready to rsp_*. Zero added latency.
- A locally answered error is available the cycle after accept if it is at head.
- Reset (asynchronous, mid-operation allowed) clears count, pointers and protocol_error. Outstanding entries are discarded.
- Outputs during and after reset with empty FIFO: req_ready=0 during RST. rsp_ready=0, mem_put_enable=0, mem_get_enable=0, rsp_data=0, rsp_misaligned=0, protocol_error=0.

## Test plan
- Load word addr 0x100, memory returns 0xDEADBEEF: put_request={0,0x100,0}; rsp_data=0xDEADBEEF, rsp_misaligned=0.
- Signed byte load addr 0x103, mem data 0x80FF0000: rsp_data=0xFFFFFF80. Unsigned gives 0x00000080.
- Store half 0xABCD to 0x22: put_request byte_en=4'b1100, addr 0x20, data 0xABCDABCD; response rsp_data=0.
- Half load at 0x101, then word load at 0x200: first response misaligned=1 with no memory traffic. Second returns memory data, in order.
- Issue DEPTH loads with mem_get_ready=0: req_ready drops to 0 after DEPTH accepts. One dequeue re-enables acceptance on the next cycle.
- Memory echoes addr 0x204 for head 0x200: protocol_error=1 and held. Assert RST mid-stream: all outputs return to reset values immediately.

Source files
------------

// File: rtl/mem_requester_if.sv
// Load/store-unit and word-memory handshake bundle for mem_requester.
// The master modport is the requester's view; slave is the core/memory side.
interface mem_requester_if;
  logic        req_enable;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_enable;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;
  logic        mem_put_enable;
  logic        mem_put_ready;
  logic [67:0] mem_put_request;
  logic        mem_get_enable;
  logic        mem_get_ready;
  logic [67:0] mem_get_response;
  logic        protocol_error;

  modport master (
    input  req_enable, req_store, req_size, req_unsigned, req_addr, req_data,
    input  rsp_enable, mem_put_ready, mem_get_ready, mem_get_response,
    output req_ready, rsp_ready, rsp_data, rsp_misaligned,
    output mem_put_enable, mem_put_request, mem_get_enable, protocol_error
  );

  modport slave (
    output req_enable, req_store, req_size, req_unsigned, req_addr, req_data,
    output rsp_enable, mem_put_ready, mem_get_ready, mem_get_response,
    input  req_ready, rsp_ready, rsp_data, rsp_misaligned,
    input  mem_put_enable, mem_put_request, mem_get_enable, protocol_error
  );
endinterface

// File: rtl/mem_requester.sv
// Sized load/store to aligned word-memory bridge with an in-order metadata FIFO;
// misaligned accesses are answered locally without touching memory.
module mem_requester #(
  parameter int DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  mem_requester_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic        is_local;
    logic        store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  off;
    logic [29:0] waddr;
  } meta_t;

  meta_t         fifo_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          perr_q, perr_d;

  logic [1:0]  off;
  logic        misaligned, not_full, empty, enq, deq, consume, mismatch;
  logic [3:0]  be;
  logic [31:0] put_data, shifted, load_val;
  meta_t       head, entry;

  assign off = bus.req_addr[1:0];

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    be         = '0;
    put_data   = '0;
    misaligned = 1'b0;
    case (bus.req_size)
      2'd0: begin
        be       = 4'b0001 << off;
        put_data = {4{bus.req_data[7:0]}};
      end
      2'd1: begin
        misaligned = off[0];
        be         = 4'b0011 << off;
        put_data   = {2{bus.req_data[15:0]}};
      end
      2'd2: begin
        misaligned = (off != 2'd0);
        be         = 4'b1111;
        put_data   = bus.req_data;
      end
      default: misaligned = 1'b1;
    endcase
    if (!bus.req_store) begin
      be       = '0;
      put_data = '0;
    end
  end

  assign entry = '{is_local: misaligned, store: bus.req_store, size: bus.req_size,
                   is_unsigned: bus.req_unsigned, off: off, waddr: bus.req_addr[31:2]};

  assign not_full = (count_q < FULL);
  assign empty    = (count_q == '0);
  assign head     = fifo_q[head_q];

  // Full blocks acceptance even when the head drains this same cycle.
  assign bus.req_ready       = !rst && not_full && (misaligned || bus.mem_put_ready);
  assign bus.mem_put_enable  = bus.req_enable && !misaligned && not_full;
  assign bus.mem_put_request = {be, bus.req_addr[31:2], 2'b00, put_data};

  assign bus.rsp_ready      = !empty && (head.is_local || bus.mem_get_ready);
  assign bus.mem_get_enable = !empty && !head.is_local && bus.rsp_enable;
  assign bus.rsp_misaligned = !empty && head.is_local;
  assign bus.protocol_error = perr_q;

  assign enq     = bus.req_enable && bus.req_ready;
  assign deq     = bus.rsp_enable && bus.rsp_ready;
  assign consume = bus.mem_get_enable && bus.mem_get_ready;

  always_comb begin
    shifted = bus.mem_get_response[31:0] >> {head.off, 3'b000};
    case (head.size)
      2'd0:    load_val = {{24{shifted[7] & ~head.is_unsigned}}, shifted[7:0]};
      2'd1:    load_val = {{16{shifted[15] & ~head.is_unsigned}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
    bus.rsp_data = (!empty && !head.is_local && !head.store) ? load_val : '0;
  end

  // A non-zero byte_en echo must line up with a store at the head, and vice versa.
  assign mismatch = (bus.mem_get_response[63:32] != {head.waddr, 2'b00}) ||
                    ((bus.mem_get_response[67:64] != 4'b0000) != head.store);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + 1'b1;
    if (deq) head_d = head_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    perr_d = perr_q | (consume & mismatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments only.
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      perr_q  <= perr_d;
    end
  end

  // NOTE: metadata storage is not reset; count gates every use of its contents.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[tail_q] <= entry;
  end
endmodule

// File: tb/tb_mem_requester.sv
// Directed scenarios followed by randomized traffic against a byte-level
// reference model of the core view and a separate memory responder.
module tb_mem_requester;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_requester_if bus ();
  mem_requester #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_local;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [67:0] mq[$];
  logic [7:0]  smem[64];
  logic [7:0]  rmem[64];
  exp_t        front;
  bit          have, exp_rr, exp_qr, mis;
  logic        st, un;
  logic [1:0]  sz;
  logic [31:0] a, d, v, word, pa, pd, edat;
  logic [3:0]  ebe, pbe;
  int          ai, wi, nbytes;

  task automatic check(string tag, logic [67:0] obs, logic [67:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.req_enable       = 1'b0;
    bus.rsp_enable       = 1'b0;
    bus.mem_put_ready    = 1'b0;
    bus.mem_get_ready    = 1'b0;
    bus.mem_get_response = '0;
  endtask

  task automatic req(logic s, logic [1:0] z, logic u, logic [31:0] ad, logic [31:0] dt);
    bus.req_enable    = 1'b1;
    bus.req_store     = s;
    bus.req_size      = z;
    bus.req_unsigned  = u;
    bus.req_addr      = ad;
    bus.req_data      = dt;
    bus.mem_put_ready = 1'b1;
  endtask

  task automatic mresp(logic [67:0] r);
    bus.mem_get_ready    = 1'b1;
    bus.mem_get_response = r;
    bus.rsp_enable       = 1'b1;
  endtask

  task automatic check_reset_outputs(string pfx);
    check({pfx, "_req_ready"}, bus.req_ready, 1'b0);
    check({pfx, "_rsp_ready"}, bus.rsp_ready, 1'b0);
    check({pfx, "_put_en"}, bus.mem_put_enable, 1'b0);
    check({pfx, "_get_en"}, bus.mem_get_enable, 1'b0);
    check({pfx, "_rsp_data"}, bus.rsp_data, 32'h0);
    check({pfx, "_rsp_mis"}, bus.rsp_misaligned, 1'b0);
    check({pfx, "_perr"}, bus.protocol_error, 1'b0);
  endtask

  initial begin
    idle();
    bus.req_store = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_data = '0;
    bus.mem_put_ready = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Word load from 0x100
    req(1'b0, 2'd2, 1'b0, 32'h100, 32'h5555_5555); #1;
    check("t1_req_ready", bus.req_ready, 1'b1);
    check("t1_put_en", bus.mem_put_enable, 1'b1);
    check("t1_put_req", bus.mem_put_request, {4'h0, 32'h100, 32'h0});
    @(negedge clk); idle(); #1;
    check("t1_wait", bus.rsp_ready, 1'b0);
    mresp({4'h0, 32'h100, 32'hDEAD_BEEF}); #1;
    check("t1_rsp_ready", bus.rsp_ready, 1'b1);
    check("t1_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
    check("t1_rsp_mis", bus.rsp_misaligned, 1'b0);
    check("t1_get_en", bus.mem_get_enable, 1'b1);
    @(negedge clk); idle(); #1;
    check("t1_empty", bus.rsp_ready, 1'b0);

    // Signed then unsigned byte load at 0x103
    req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0); #1;
    check("t2_put_req", bus.mem_put_request, {4'h0, 32'h100, 32'h0});
    @(negedge clk); idle(); mresp({4'h0, 32'h100, 32'h80FF_0000}); #1;
    check("t2_signed", bus.rsp_data, 32'hFFFF_FF80);
    @(negedge clk); idle(); req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    @(negedge clk); idle(); mresp({4'h0, 32'h100, 32'h80FF_0000}); #1;
    check("t2_unsigned", bus.rsp_data, 32'h0000_0080);

    // Half store 0xABCD to 0x22
    @(negedge clk); idle(); req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_ABCD); #1;
    check("t3_put_req", bus.mem_put_request, {4'b1100, 32'h20, 32'hABCD_ABCD});
    @(negedge clk); idle(); mresp({4'b1100, 32'h20, 32'h0}); #1;
    check("t3_rsp_ready", bus.rsp_ready, 1'b1);
    check("t3_rsp_data", bus.rsp_data, 32'h0);
    check("t3_rsp_mis", bus.rsp_misaligned, 1'b0);

    // Misaligned half at 0x101 then word at 0x200, answered in order
    @(negedge clk); idle(); req(1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
    bus.mem_put_ready = 1'b0; #1;
    check("t4_mis_ready", bus.req_ready, 1'b1);
    check("t4_mis_put_en", bus.mem_put_enable, 1'b0);
    @(negedge clk); idle(); req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    bus.rsp_enable = 1'b1; #1;
    check("t4_local_ready", bus.rsp_ready, 1'b1);
    check("t4_local_mis", bus.rsp_misaligned, 1'b1);
    check("t4_local_data", bus.rsp_data, 32'h0);
    check("t4_local_get_en", bus.mem_get_enable, 1'b0);
    check("t4_word_put_en", bus.mem_put_enable, 1'b1);
    @(negedge clk); idle(); mresp({4'h0, 32'h200, 32'h1234_5678}); #1;
    check("t4_word_data", bus.rsp_data, 32'h1234_5678);
    check("t4_word_mis", bus.rsp_misaligned, 1'b0);

    // Fill to DEPTH with memory stalled; one dequeue frees a slot next cycle
    @(negedge clk); idle(); req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0); #1;
    check("t5_acc0", bus.req_ready, 1'b1);
    @(negedge clk); req(1'b0, 2'd2, 1'b0, 32'h304, 32'h0); #1;
    check("t5_acc1", bus.req_ready, 1'b1);
    @(negedge clk); idle(); bus.mem_put_ready = 1'b1; #1;
    check("t5_full", bus.req_ready, 1'b0);
    @(negedge clk); mresp({4'h0, 32'h300, 32'hAAAA_0001}); bus.mem_put_ready = 1'b1; #1;
    check("t5_full_deq", bus.req_ready, 1'b0);
    check("t5_first", bus.rsp_data, 32'hAAAA_0001);
    @(negedge clk); idle(); bus.mem_put_ready = 1'b1;
    mresp({4'h0, 32'h304, 32'hAAAA_0002}); #1;
    check("t5_reopen", bus.req_ready, 1'b1);
    check("t5_second", bus.rsp_data, 32'hAAAA_0002);

    // Address echo mismatch sets a sticky error; async reset clears everything
    @(negedge clk); idle(); req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    @(negedge clk); idle(); mresp({4'h0, 32'h204, 32'h0}); #1;
    check("t6_perr_pre", bus.protocol_error, 1'b0);
    @(negedge clk); idle(); #1;
    check("t6_perr_set", bus.protocol_error, 1'b1);
    @(negedge clk); #1;
    check("t6_perr_held", bus.protocol_error, 1'b1);
    @(negedge clk); req(1'b0, 2'd3, 1'b0, 32'h400, 32'h0);
    @(negedge clk); idle(); bus.mem_put_ready = 1'b1; #1;
    check("t6_pre_rst_rsp", bus.rsp_ready, 1'b1);
    #1 rst = 1'b1; #1;
    check_reset_outputs("t6_midrst");
    @(negedge clk); rst = 1'b0; #1;
    check("t6_post_rsp", bus.rsp_ready, 1'b0);
    check("t6_post_ready", bus.req_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 64; i++) begin
      smem[i] = 8'($urandom);
      rmem[i] = smem[i];
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      idle();
      have  = (exp_q.size() != 0);
      front = have ? exp_q[0] : '0;
      bus.mem_get_ready    = (mq.size() != 0) && ($urandom_range(0, 3) != 0);
      bus.mem_get_response = (mq.size() != 0) ? mq[0] : '0;
      exp_rr = have && (front.is_local || bus.mem_get_ready);
      bus.rsp_enable = exp_rr && ($urandom_range(0, 2) != 0);

      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      d  = $urandom;
      ai = int'(a);
      nbytes = 1 << sz;
      mis = (sz == 2'd3) || (ai % nbytes != 0);
      bus.mem_put_ready = ($urandom_range(0, 3) != 0);
      exp_qr = (exp_q.size() < DEPTH) && (mis || bus.mem_put_ready);
      bus.req_store = st; bus.req_size = sz; bus.req_unsigned = un;
      bus.req_addr = a; bus.req_data = d;
      bus.req_enable = exp_qr && ($urandom_range(0, 3) != 0);
      #1;
      check("r_req_ready", bus.req_ready, exp_qr);
      check("r_rsp_ready", bus.rsp_ready, exp_rr);
      check("r_put_en", bus.mem_put_enable, bus.req_enable && !mis);
      check("r_get_en", bus.mem_get_enable, have && !front.is_local && bus.rsp_enable);
      if (exp_rr) begin
        check("r_rsp_mis", bus.rsp_misaligned, front.is_local);
        check("r_rsp_data", bus.rsp_data, front.data);
      end

      if (bus.rsp_enable) begin
        if (!front.is_local) void'(mq.pop_front());
        void'(exp_q.pop_front());
      end
      if (bus.req_enable) begin
        if (mis) begin
          exp_q.push_back(exp_t'{1'b1, 32'h0});
        end else begin
          ebe = '0; edat = '0; v = '0;
          if (st) begin
            for (int k = 0; k < nbytes; k++) ebe[ai % 4 + k] = 1'b1;
            for (int j = 0; j < 4; j++) edat[8*j +: 8] = d[8*(j % nbytes) +: 8];
          end
          check("r_put_req", bus.mem_put_request, {ebe, a & 32'hFFFF_FFFC, edat});
          pbe = bus.mem_put_request[67:64];
          pa  = bus.mem_put_request[63:32];
          pd  = bus.mem_put_request[31:0];
          wi  = int'(pa[5:2]) * 4;
          if (st) begin
            for (int k = 0; k < 4; k++) if (pbe[k]) rmem[wi + k] = pd[8*k +: 8];
            mq.push_back({pbe, pa, 32'h0});
            for (int k = 0; k < nbytes; k++) smem[ai + k] = d[8*k +: 8];
            exp_q.push_back(exp_t'{1'b0, 32'h0});
          end else begin
            word = {rmem[wi + 3], rmem[wi + 2], rmem[wi + 1], rmem[wi]};
            mq.push_back({pbe, pa, word});
            for (int k = 0; k < nbytes; k++) v[8*k +: 8] = smem[ai + k];
            if (!un && nbytes < 4 && v[8*nbytes - 1])
              for (int k = nbytes; k < 4; k++) v[8*k +: 8] = 8'hFF;
            exp_q.push_back(exp_t'{1'b0, v});
          end
        end
      end
    end
    @(negedge clk); idle(); #1;
    check("r_perr_clear", bus.protocol_error, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
